// File: rtl/operand_shifter_if.sv
// Handshake and operand bus between decode, the operand shifter and the ALU.
// master drives the upstream beat and downstream ready; slave is the shifter.
interface operand_shifter_if #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 5
) ();
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic [1:0]        in_shift_type;
  logic              in_shift_by_reg;
  logic [4:0]        in_imm5;
  logic [7:0]        in_rs;
  logic [CMD_W-1:0]  in_cmd;
  logic              cflag_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              src2shift_carry;
  logic              was_shifted;
  logic [CMD_W-1:0]  CTRL_cmd;

  modport master (
    output flush, in_valid, in_src1, in_src2, in_shift_type, in_shift_by_reg,
           in_imm5, in_rs, in_cmd, cflag_in, out_ready,
    input  in_ready, out_valid, src1, src2, src2shift_carry, was_shifted, CTRL_cmd
  );

  modport slave (
    input  flush, in_valid, in_src1, in_src2, in_shift_type, in_shift_by_reg,
           in_imm5, in_rs, in_cmd, cflag_in, out_ready,
    output in_ready, out_valid, src1, src2, src2shift_carry, was_shifted, CTRL_cmd
  );
endinterface

// File: rtl/operand_shifter.sv
// ARM-style barrel shift of operand 2 in a single registered valid/ready stage.
// Define SHIFTER_REG_AMOUNT_EN to enable register-specified shift amounts.
module operand_shifter #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 5
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  operand_shifter_if.slave bus
);

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;

  function automatic logic [DATA_W-1:0] ror_w(input logic [DATA_W-1:0] x,
                                              input logic [4:0] n);
    logic [5:0] back;
    back = 6'd32 - {1'b0, n};
    return (x >> n) | (x << back);
  endfunction

  // Returns {carry, result}; amount 0 selects the #32 / RRX encodings.
  function automatic logic [DATA_W:0] shift_imm(input logic [1:0] t,
                                                input logic [4:0] n,
                                                input logic [DATA_W-1:0] x,
                                                input logic cin);
    logic [4:0]               nm1;
    logic [4:0]               inv;
    logic signed [DATA_W-1:0] xs;
    logic [DATA_W-1:0]        r;
    nm1 = n - 5'd1;
    inv = 5'd0 - n;
    xs  = x;
    case (t)
      LSL: begin
        if (n == 5'd0) return {cin, x};
        return {x[inv], x << n};
      end
      LSR: begin
        if (n == 5'd0) return {x[DATA_W-1], {DATA_W{1'b0}}};
        return {x[nm1], x >> n};
      end
      ASR: begin
        if (n == 5'd0) return {x[DATA_W-1], {DATA_W{x[DATA_W-1]}}};
        r = xs >>> n;
        return {x[nm1], r};
      end
      default: begin
        if (n == 5'd0) return {x[0], cin, x[DATA_W-1:1]};
        r = ror_w(x, n);
        return {r[DATA_W-1], r};
      end
    endcase
  endfunction

`ifdef SHIFTER_REG_AMOUNT_EN
  // Amounts 1..31 behave exactly like the immediate form.
  function automatic logic [DATA_W:0] shift_reg(input logic [1:0] t,
                                                input logic [7:0] m,
                                                input logic [DATA_W-1:0] x,
                                                input logic cin);
    logic              big;
    logic [DATA_W-1:0] r;
    big = |m[7:5];
    if (m == 8'd0) return {cin, x};
    case (t)
      LSL: begin
        if (!big) return shift_imm(LSL, m[4:0], x, cin);
        if (m == 8'd32) return {x[0], {DATA_W{1'b0}}};
        return {1'b0, {DATA_W{1'b0}}};
      end
      LSR: begin
        if (!big) return shift_imm(LSR, m[4:0], x, cin);
        if (m == 8'd32) return {x[DATA_W-1], {DATA_W{1'b0}}};
        return {1'b0, {DATA_W{1'b0}}};
      end
      ASR: begin
        if (!big) return shift_imm(ASR, m[4:0], x, cin);
        return {x[DATA_W-1], {DATA_W{x[DATA_W-1]}}};
      end
      default: begin
        if (m[4:0] == 5'd0) return {x[DATA_W-1], x};
        r = ror_w(x, m[4:0]);
        return {r[DATA_W-1], r};
      end
    endcase
  endfunction
`endif

  logic [DATA_W:0]   w_shift_p0;
  logic              w_sh_p0;
  logic              w_accept_p0;
  logic              r_vld_p1;
  logic [DATA_W-1:0] r_src1_p1;
  logic [DATA_W-1:0] r_src2_p1;
  logic              r_carry_p1;
  logic              r_sh_p1;
  logic [CMD_W-1:0]  r_cmd_p1;

  // Stage p0: combinational shift of the incoming beat
  always_comb begin
    w_shift_p0 = shift_imm(bus.in_shift_type, bus.in_imm5, bus.in_src2, bus.cflag_in);
    w_sh_p0    = !((bus.in_shift_type == LSL) && (bus.in_imm5 == 5'd0));
`ifdef SHIFTER_REG_AMOUNT_EN
    if (bus.in_shift_by_reg) begin
      w_shift_p0 = shift_reg(bus.in_shift_type, bus.in_rs, bus.in_src2, bus.cflag_in);
      w_sh_p0    = |bus.in_rs;
    end
`endif
  end

`ifndef SHIFTER_REG_AMOUNT_EN
  logic w_unused;
  assign w_unused = ^{bus.in_rs, bus.in_shift_by_reg};
`endif

  assign bus.in_ready = !r_vld_p1 || bus.out_ready;
  assign w_accept_p0  = bus.in_valid && bus.in_ready && !bus.flush;

  // Stage p1: output register toward the ALU
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      r_vld_p1   <= 1'b0;
      r_src1_p1  <= '0;
      r_src2_p1  <= '0;
      r_carry_p1 <= 1'b0;
      r_sh_p1    <= 1'b0;
      r_cmd_p1   <= '0;
    end else begin
      if (bus.flush)         r_vld_p1 <= 1'b0;
      else if (w_accept_p0)  r_vld_p1 <= 1'b1;
      else if (bus.out_ready) r_vld_p1 <= 1'b0;
      if (w_accept_p0) begin
        r_src1_p1  <= bus.in_src1;
        r_src2_p1  <= w_shift_p0[DATA_W-1:0];
        r_carry_p1 <= w_shift_p0[DATA_W];
        r_sh_p1    <= w_sh_p0;
        r_cmd_p1   <= bus.in_cmd;
      end
    end
  end

  assign bus.out_valid       = r_vld_p1;
  assign bus.src1            = r_src1_p1;
  assign bus.src2            = r_src2_p1;
  assign bus.src2shift_carry = r_carry_p1;
  assign bus.was_shifted     = r_sh_p1;
  assign bus.CTRL_cmd        = r_cmd_p1;

endmodule

// File: tb/tb_operand_shifter.sv
// Randomized and directed bench for operand_shifter against a 64-bit arithmetic
// reference model of the shift rules and a one-entry handshake model.
module tb_operand_shifter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  operand_shifter_if bus ();
  operand_shifter dut (.CLOCK_50(clk), .rst_n(rst_n), .bus(bus));

`ifdef SHIFTER_REG_AMOUNT_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bit          exp_vld;
  logic [31:0] e_src1, e_src2;
  logic        e_c, e_sh;
  logic [4:0]  e_cmd;
  bit          last_acc;
  logic [31:0] delivered[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {was_shifted, carry, result}
  function automatic logic [33:0] ref_shift(input logic [1:0] t, input logic byreg,
                                            input logic [4:0] imm, input logic [7:0] rs,
                                            input logic [31:0] x, input logic cin);
    int                amt;
    logic [63:0]       w;
    logic signed [63:0] s;
    logic [31:0]       r;
    logic              c;
    if (byreg && REG_EN) begin
      if (rs == 8'd0) return {1'b0, cin, x};
      amt = int'(rs);
    end else if (imm == 5'd0) begin
      if (t == 2'd0) return {1'b0, cin, x};
      if (t == 2'd3) return {1'b1, x[0], cin, x[31:1]};
      amt = 32;
    end else begin
      amt = int'(imm);
    end
    case (t)
      2'd0: begin w = {32'b0, x} << amt; r = w[31:0];  c = w[32]; end
      2'd1: begin w = {x, 32'b0} >> amt; r = w[63:32]; c = w[31]; end
      2'd2: begin
        s = {x, 32'b0};
        s = s >>> ((amt > 32) ? 32 : amt);
        r = s[63:32]; c = s[31];
      end
      default: begin w = {x, x} >> (amt % 32); r = w[31:0]; c = r[31]; end
    endcase
    return {1'b1, c, r};
  endfunction

  task automatic step();
    logic [33:0] m;
    bit acc;
    #2;
    check("out_valid", bus.out_valid, exp_vld);
    check("in_ready", bus.in_ready, !exp_vld || bus.out_ready);
    check("src1", bus.src1, e_src1);
    check("src2_c_sh_cmd", {bus.src2, bus.src2shift_carry, bus.was_shifted, bus.CTRL_cmd},
          {e_src2, e_c, e_sh, e_cmd});
    if (bus.out_valid && bus.out_ready) delivered.push_back(bus.src1);
    m   = ref_shift(bus.in_shift_type, bus.in_shift_by_reg, bus.in_imm5, bus.in_rs,
                    bus.in_src2, bus.cflag_in);
    acc = rst_n && bus.in_valid && (!exp_vld || bus.out_ready) && !bus.flush;
    @(posedge clk);
    if (!rst_n) begin
      exp_vld = 0; e_src1 = '0; e_src2 = '0; e_c = 0; e_sh = 0; e_cmd = '0;
    end else begin
      if (acc) begin
        e_src1 = bus.in_src1; e_src2 = m[31:0]; e_c = m[32]; e_sh = m[33]; e_cmd = bus.in_cmd;
      end
      if (bus.flush) exp_vld = 0;
      else if (acc) exp_vld = 1;
      else if (bus.out_ready) exp_vld = 0;
    end
    last_acc = acc;
    #1;
  endtask

  task automatic set_beat(input logic [1:0] t, input logic br, input logic [4:0] imm,
                          input logic [7:0] rs, input logic [31:0] x, input logic cin);
    bus.in_shift_type = t; bus.in_shift_by_reg = br; bus.in_imm5 = imm;
    bus.in_rs = rs; bus.in_src2 = x; bus.cflag_in = cin;
    bus.in_src1 = $urandom; bus.in_cmd = 5'($urandom);
  endtask

  task automatic dir(input string tag, input logic [1:0] t, input logic br,
                     input logic [4:0] imm, input logic [7:0] rs, input logic [31:0] x,
                     input logic cin, input logic [31:0] er, input logic ec, input logic esh);
    set_beat(t, br, imm, rs, x, cin);
    bus.in_valid = 1; bus.out_ready = 1; bus.flush = 0;
    step();
    check(tag, {bus.src2, bus.src2shift_carry, bus.was_shifted}, {er, ec, esh});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    bus.flush = 0; bus.in_valid = 1; bus.out_ready = 0;
    set_beat(2'd0, 1'b0, 5'd3, 8'd0, 32'h1234_5678, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    exp_vld = 0; e_src1 = '0; e_src2 = '0; e_c = 0; e_sh = 0; e_cmd = '0;
    step();
    rst_n = 1;
    bus.in_valid = 0;
    step();

    // Immediate edge cases
    dir("imm_lsl0", 2'd0, 1'b0, 5'd0, 8'd0, 32'h8000_0001, 1'b1, 32'h8000_0001, 1'b1, 1'b0);
    dir("imm_lsr0", 2'd1, 1'b0, 5'd0, 8'd0, 32'h8000_0001, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
    dir("imm_asr0", 2'd2, 1'b0, 5'd0, 8'd0, 32'h8000_0001, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    dir("imm_rrx",  2'd3, 1'b0, 5'd0, 8'd0, 32'h8000_0001, 1'b1, 32'hC000_0000, 1'b1, 1'b1);
    dir("imm_lsl1", 2'd0, 1'b0, 5'd1, 8'd0, 32'h8000_0001, 1'b1, 32'h0000_0002, 1'b1, 1'b1);
    dir("imm_ror8", 2'd3, 1'b0, 5'd8, 8'd0, 32'h1234_5678, 1'b0, 32'h7812_3456, 1'b0, 1'b1);
`ifdef SHIFTER_REG_AMOUNT_EN
    dir("reg_lsl32", 2'd0, 1'b1, 5'd7, 8'd32,  32'h0000_0001, 1'b0, 32'h0, 1'b1, 1'b1);
    dir("reg_lsl33", 2'd0, 1'b1, 5'd7, 8'd33,  32'h0000_0001, 1'b0, 32'h0, 1'b0, 1'b1);
    dir("reg_ror32", 2'd3, 1'b1, 5'd7, 8'd32,  32'h0000_0001, 1'b0, 32'h1, 1'b0, 1'b1);
    dir("reg_ror0",  2'd3, 1'b1, 5'd7, 8'd0,   32'h0000_0001, 1'b0, 32'h1, 1'b0, 1'b0);
    dir("reg_asr200", 2'd2, 1'b1, 5'd7, 8'd200, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1);
`else
    dir("noreg_lsl", 2'd0, 1'b1, 5'd0, 8'd4, 32'h0000_00F1, 1'b0, 32'h0000_00F1, 1'b0, 1'b0);
    dir("noreg_lsr", 2'd1, 1'b1, 5'd4, 8'd0, 32'h0000_00F1, 1'b1, 32'h0000_000F, 1'b0, 1'b1);
`endif
    bus.in_valid = 0;
    step();

    // Backpressure: three beats, ALU stalls for cycles 2..4
    delivered.delete();
    begin
      int sent = 0;
      for (int cyc = 1; cyc < 40 && delivered.size() < 3; cyc++) begin
        if (sent < 3) begin
          if (cyc == 1 || last_acc) begin
            set_beat(2'($urandom), 1'($urandom), 5'($urandom), 8'($urandom), $urandom, 1'($urandom));
            bus.in_src1 = 32'(sent + 1);
          end
          bus.in_valid = 1;
        end else begin
          bus.in_valid = 0;
        end
        bus.out_ready = !(cyc >= 2 && cyc <= 4);
        step();
        if (last_acc) sent++;
      end
    end
    check("bp_count", 64'(delivered.size()), 64'd3);
    for (int i = 0; i < delivered.size(); i++) check("bp_order", delivered[i], 32'(i + 1));
    bus.in_valid = 0; bus.out_ready = 1;
    step();

    // Flush collides with a full stage and an incoming beat
    set_beat(2'd0, 1'b0, 5'd2, 8'd0, 32'h0000_0003, 1'b0);
    bus.in_src1 = 32'h0000_0055; bus.in_valid = 1; bus.out_ready = 0;
    step();
    set_beat(2'd1, 1'b0, 5'd1, 8'd0, 32'hFFFF_0000, 1'b0);
    bus.in_src1 = 32'h0000_DEAD; bus.flush = 1;
    step();
    check("flush_valid", bus.out_valid, 1'b0);
    check("flush_src1", bus.src1, 32'h0000_0055);
    bus.flush = 0;
    set_beat(2'd0, 1'b0, 5'd4, 8'd0, 32'h0000_0001, 1'b0);
    bus.in_src1 = 32'h0000_0077;
    step();
    check("post_flush", {bus.out_valid, bus.src1, bus.src2}, {1'b1, 32'h0000_0077, 32'h0000_0010});
    bus.in_valid = 0; bus.out_ready = 1;
    step();

    // Reset while stalled drops the held beat
    bus.in_valid = 1; bus.out_ready = 0;
    step();
    step();
    rst_n = 0;
    step();
    rst_n = 1; bus.in_valid = 0;
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] imm;
      logic [7:0] rs;
      imm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      case ($urandom_range(0, 5))
        0: rs = 8'd0;
        1: rs = 8'd32;
        2: rs = 8'd33;
        3: rs = 8'($urandom_range(1, 31));
        4: rs = 8'd64;
        default: rs = 8'($urandom);
      endcase
      set_beat(2'($urandom), 1'($urandom), imm, rs, $urandom, 1'($urandom));
      bus.in_valid  = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_shifter.md
Name: operand_shifter

Overview:
- Pipeline stage directly upstream of the ALU.
- Applies the ARM-style barrel shift to the second operand.
- Produces the aligned operand pair plus `src2shift_carry` and `was_shifted`, and forwards the 5-bit ALU command.
- Uses a single registered stage with a valid/ready handshake, so decode stalls and flushes are absorbed before the ALU.

Parameters:
- DATA_W, 32, operand width; shift rules below are defined for 32 only.
- CMD_W, 5, width of forwarded ALU command.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard the held entry and any accept this cycle.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_src1  in  32  first operand, passed through unchanged.
- in_src2  in  32  operand to shift.
- in_shift_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- in_shift_by_reg  in  1  0 = immediate amount, 1 = register amount.
- in_imm5  in  5  immediate shift amount.
- in_rs  in  8  register shift amount (low byte of Rs).
- in_cmd  in  5  ALU command, passed through.
- cflag_in  in  1  current C flag from the flag register.
- out_valid  out  1  output beat valid.
- out_ready  in  1  ALU stage accepts the beat.
- src1  out  32  registered in_src1.
- src2  out  32  shifted operand.
- src2shift_carry  out  1  shifter carry-out.
- was_shifted  out  1  1 when src2shift_carry came from the shifter, 0 when it equals cflag_in.
- CTRL_cmd  out  5  registered in_cmd.

Behaviour:
- Reset, sampled only on a CLOCK_50 edge with rst_n=0: out_valid=0, src1=0, src2=0, src2shift_carry=0, was_shifted=0, CTRL_cmd=0. Reset mid-stall drops the held beat.
- Handshake:
  - in_ready = !out_valid || out_ready; this is combinational and involves no in_valid→in_ready path.
  - A beat is accepted when in_valid && in_ready && !flush.
  - The shift is computed combinationally and registered on accept. Latency is 1 cycle; throughput is 1 beat/cycle.
- out_valid next state:
  - flush=1: 0, with priority over everything.
  - else accept: 1.
  - else out_ready: 0.
  - else hold.
- Output data regs hold value whenever no accept occurs. Data is stable while out_valid && !out_ready.
- Immediate mode (in_shift_by_reg=0), n = in_imm5:
  - LSL n=0: src2 = in_src2, carry = cflag_in, was_shifted=0.
  - LSL n=1..31: src2 = in_src2 << n, carry = in_src2[32-n].
  - LSR n=0 means LSR#32: result 0, carry = in_src2[31].
  - LSR other n: logical right shift, carry = in_src2[n-1].
  - ASR n=0 means ASR#32: result all in_src2[31], carry = in_src2[31].
  - ASR other n: arithmetic right shift, carry = in_src2[n-1].
  - ROR n=0 means RRX: result {cflag_in, in_src2[31:1]}, carry = in_src2[0].
  - ROR other n: rotate right n, carry = result[31].
  - was_shifted=1 in every case except LSL#0.
- Register mode (in_shift_by_reg=1), m = in_rs[7:0]:
  - m=0, any type: src2 unchanged, carry = cflag_in, was_shifted=0.
  - LSL 1..31: as immediate. LSL 32: result 0, carry in_src2[0]. LSL >32: result 0, carry 0.
  - LSR 1..31: as immediate. LSR 32: result 0, carry in_src2[31]. LSR >32: result 0, carry 0.
  - ASR ≥32: all bits = in_src2[31], carry in_src2[31].
  - ROR with m[4:0]=0 (m≠0): result unchanged, carry in_src2[31].
  - ROR otherwise: rotate by m[4:0], carry = result[31].
  - was_shifted=1 whenever m≠0.
- cflag_in is sampled in the accept cycle only.

Optional Feature:
- Macro: SHIFTER_REG_AMOUNT_EN.
- Defined: register-mode behaviour as above.
- Undefined:
  - in_shift_by_reg and in_rs are ignored, and the register-amount logic is not synthesised.
  - Every beat uses immediate-mode rules.
  - Port list unchanged.

Test Plan:
- Reset then idle: rst_n=0 for 2 edges with in_valid=1 → out_valid=0, in_ready=1, all data outputs 0; first beat after rst_n=1 appears 1 cycle later.
- Immediate edge cases, in_src2=0x80000001, cflag_in=1:
  - LSL#0 → 0x80000001, C=1, was_shifted=0.
  - LSR#0 → 0x00000000, C=1.
  - ASR#0 → 0xFFFFFFFF, C=1.
  - ROR#0 (RRX) → 0xC0000000, C=1, was_shifted=1.
  - LSL#1 → 0x00000002, C=1.
- Register amounts, in_src2=0x00000001, cflag_in=0:
  - LSL rs=32 → 0, C=1.
  - LSL rs=33 → 0, C=0.
  - ROR rs=32 → 0x00000001, C=0.
  - ROR rs=0 → unchanged, C=0, was_shifted=0.
  - ASR rs=200 on 0x80000000 → 0xFFFFFFFF, C=1.
- Backpressure: 3 back-to-back beats, out_ready=0 for cycles 2–4 → in_ready=0 while full, beat 1 held stable, no beat lost or duplicated, all 3 delivered in order once out_ready=1.
- Flush: flush=1 with out_valid=1 and in_valid=1 the same cycle → next cycle out_valid=0, incoming beat discarded; following beat accepted normally.
- Macro undefined: in_shift_by_reg=1, in_rs=4, in_imm5=0, LSL → src2 unchanged, was_shifted=0, i.e. the immediate rule applies.
